led_cube_playlist_scheduler: RTL and testbench
==============================================

Name: led_cube_playlist_scheduler

Overview:
- Sequences stored animations for the cube frame driver from a small programmable playlist.
- Each slot holds {valid, anim_id, loops}; the block steps frame_index through each animation, repeats it loops+1 times, then advances to the next valid slot with wrap-around.
- Paces frames with a tick timer and handshakes with the single-frame driver (frame_start out, frame_done in).
- Sits between the host config/control registers and the frame driver plus animation ROM select.

Parameters:
- NUM_SLOTS, 8, playlist depth; power of two.
- FRAME_TICKS, 1500000, clk cycles per frame period.
- FRAMES_PER_ANIM, 150, frames per animation; frame_index wraps at FRAMES_PER_ANIM-1.
- ANIM_W, 3, anim_id width.
- LOOP_W, 3, loops field width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cfg_we  in  1  playlist slot write strobe
- cfg_addr  in  $clog2(NUM_SLOTS)  slot to write
- cfg_valid  in  1  slot valid bit written
- cfg_anim  in  ANIM_W  anim_id written
- cfg_loops  in  LOOP_W  repeat count written; value L plays L+1 passes
- play  in  1  start pulse
- stop  in  1  stop pulse; highest priority
- pause  in  1  level; freezes playback while high
- frame_done  in  1  single-cycle pulse from frame driver: frame scan finished
- frame_start  out  1  single-cycle pulse to frame driver
- frame_index  out  8  frame offset into animation ROM
- anim_sel  out  ANIM_W  selected animation
- playing  out  1  high in any non-IDLE state
- cur_slot  out  $clog2(NUM_SLOTS)  slot currently playing
- overrun  out  1  sticky: frame period expired before frame_done
- empty_err  out  1  single-cycle pulse: play with no valid slot

Behaviour:
- Reset: all slots invalid (entries zeroed), state IDLE, all outputs 0, timer 0, loop_cnt 0.
- Playlist is a register array. A write takes effect next cycle and is legal in any state.
- The current slot's anim_id/loops are latched on slot load, so a write to the playing slot does not affect the pass in progress.
- States: IDLE, LOAD, RUN, WAIT_DONE, PAUSED.
- IDLE:
  - play with ≥1 valid slot -> LOAD, scanning from slot 0.
  - play with none valid -> stay IDLE, pulse empty_err.
- LOAD (1 cycle):
  - latch entry of the found slot into anim_sel/cur_slot/loops_q; frame_index=0, loop_cnt=0, timer=0; -> RUN.
- RUN:
  - frame_start pulses in the cycle timer==0. Timer increments each cycle.
  - A done_seen flag sets on frame_done and clears on frame_start.
  - At timer==FRAME_TICKS-1 with done_seen (or frame_done in the same cycle): advance and set timer to 0.
  - At timer==FRAME_TICKS-1 without done_seen: -> WAIT_DONE and set overrun.
- WAIT_DONE:
  - timer holds; on frame_done, advance and return to RUN with timer=0.
- Advance:
  - frame_index+1. At FRAMES_PER_ANIM-1, frame_index wraps to 0 and loop_cnt+1.
  - When loop_cnt==loops_q at wrap, select the next valid slot after cur_slot, circular, cur_slot itself last; go to LOAD with it.
  - If no slot is valid at that moment -> IDLE, playing=0.
- PAUSED:
  - Entered from RUN when pause=1; timer, frame_index and loop_cnt hold; no frame_start.
  - pause=0 -> RUN, continuing from the held timer value.
  - pause during WAIT_DONE is deferred until after frame_done.
- stop in any state -> IDLE next cycle; frame_index/anim_sel cleared. overrun is not cleared; only reset or play clears it.
- play while not IDLE is ignored. play and stop in the same cycle: stop wins.
- frame_done in IDLE/LOAD/PAUSED is ignored (not recorded).
- The timer is $clog2(FRAME_TICKS) bits wide and never exceeds FRAME_TICKS-1. frame_index comparisons are unsigned 8-bit.
- Latency:
  - play -> LOAD is 1 cycle; first frame_start comes 2 cycles after play.
  - Frame-to-frame period is exactly FRAME_TICKS cycles when done arrives in time.

Decomposition:
- Package led_cube_sched_pkg:
  - state enum sched_state_t;
  - struct slot_t {valid, anim_id, loops};
  - default constants for FRAME_TICKS and FRAMES_PER_ANIM.
- Sub-module led_cube_next_slot:
  - combinational rotating find-next-valid over the NUM_SLOTS valid vector, starting at cur_slot+1.
  - Outputs found and index; used by both IDLE (start=0, inclusive) and advance.

Test Plan (FRAME_TICKS=4, FRAMES_PER_ANIM=3):
1. Slot0={1,anim 2,loops 1}, others invalid; play; frame_done 1 cycle after each frame_start -> anim_sel=2, frame_index 0,1,2,0,1,2 at 4-cycle spacing, then stays on slot0 (wrap to itself), 6 frame_starts per 24 cycles.
2. Slots 1={anim 3,loops 0} and 5={anim 6,loops 0}, play -> cur_slot 1 for 3 frames, then 5 for 3 frames, then 1; slots 0, 2–4, 6–7 skipped.
3. Withhold frame_done on frame 1 for 6 extra cycles -> overrun=1, timer holds; frame_index advances the cycle after frame_done; the next frame_start is 1 cycle later.
4. pause high for 10 cycles mid-frame -> no frame_start, frame_index/timer frozen; on release, the frame ends after the remaining ticks.
5. Playing slot 0; invalidate all slots via cfg_we; at the end of the pass -> IDLE, playing=0. Play with all invalid -> empty_err one pulse, stays IDLE.
6. stop and play in the same cycle while RUN -> IDLE. Reset asserted mid-RUN -> all outputs 0 next cycle and slots invalid.

Source files
------------

// File: rtl/led_cube_sched_pkg.sv
// Shared types and default constants for the LED cube playlist scheduler.
package led_cube_sched_pkg;

  localparam int unsigned FRAME_TICKS_DEF     = 1500000;
  localparam int unsigned FRAMES_PER_ANIM_DEF = 150;
  localparam int unsigned ANIM_W_DEF          = 3;
  localparam int unsigned LOOP_W_DEF          = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    WAIT_DONE,
    PAUSED
  } sched_state_t;

  typedef struct packed {
    logic                  valid;
    logic [ANIM_W_DEF-1:0] anim_id;
    logic [LOOP_W_DEF-1:0] loops;
  } slot_t;

endpackage

// File: rtl/led_cube_next_slot.sv
// Rotating find-first-valid: probes slots start, start+1, ... circularly,
// so passing cur_slot+1 visits cur_slot itself last.
module led_cube_next_slot #(
  parameter int unsigned NUM_SLOTS = 8,
  localparam int unsigned IW = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] valid_vec,
  input  logic [IW-1:0]        start,
  output logic                 found,
  output logic [IW-1:0]        index
);

  logic [IW-1:0] probe;

  // First valid slot at or after start, wrapping modulo NUM_SLOTS.
  always_comb begin
    found = 1'b0;
    index = '0;
    probe = '0;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      probe = start + IW'(k);
      if (!found && valid_vec[probe]) begin
        found = 1'b1;
        index = probe;
      end
    end
  end

endmodule

// File: rtl/led_cube_playlist_scheduler.sv
// Playlist sequencer for the LED cube: steps frames of the selected
// animation at a fixed tick period, repeats each slot loops+1 times and
// moves on to the next valid playlist slot.
module led_cube_playlist_scheduler
  import led_cube_sched_pkg::*;
#(
  parameter int unsigned NUM_SLOTS       = 8,
  parameter int unsigned FRAME_TICKS     = FRAME_TICKS_DEF,
  parameter int unsigned FRAMES_PER_ANIM = FRAMES_PER_ANIM_DEF,
  parameter int unsigned ANIM_W          = ANIM_W_DEF,
  parameter int unsigned LOOP_W          = LOOP_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_SLOTS)-1:0] cfg_addr,
  input  logic                         cfg_valid,
  input  logic [ANIM_W-1:0]            cfg_anim,
  input  logic [LOOP_W-1:0]            cfg_loops,
  input  logic                         play,
  input  logic                         stop,
  input  logic                         pause,
  input  logic                         frame_done,
  output logic                         frame_start,
  output logic [7:0]                   frame_index,
  output logic [ANIM_W-1:0]            anim_sel,
  output logic                         playing,
  output logic [$clog2(NUM_SLOTS)-1:0] cur_slot,
  output logic                         overrun,
  output logic                         empty_err
);

  localparam int unsigned SW = $clog2(NUM_SLOTS);
  localparam int unsigned TW = $clog2(FRAME_TICKS);
  localparam logic [TW-1:0] TIMER_LAST = TW'(FRAME_TICKS - 1);
  localparam logic [7:0]    FRAME_LAST = 8'(FRAMES_PER_ANIM - 1);

  sched_state_t state, state_d;

  slot_t          slots [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] valid_vec;

  logic [SW-1:0]     search_start, next_idx, load_slot, load_slot_d;
  logic              next_found;
  logic [LOOP_W-1:0] loops_q, loops_q_d, loop_cnt, loop_cnt_d;
  logic [TW-1:0]     timer, timer_d;
  logic [7:0]        frame_index_d;
  logic [ANIM_W-1:0] anim_sel_d;
  logic [SW-1:0]     cur_slot_d;
  logic              done_seen, done_seen_d;
  logic              overrun_d, empty_err_d;
  logic              advance;

  // Playlist register file; writes are accepted in every state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
    end else if (cfg_we) begin
      slots[cfg_addr] <= '{valid:   cfg_valid,
                           anim_id: ANIM_W_DEF'(cfg_anim),
                           loops:   LOOP_W_DEF'(cfg_loops)};
    end
  end

  // Gather the valid bits for the slot search.
  always_comb begin
    valid_vec = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) valid_vec[i] = slots[i].valid;
  end

  // IDLE searches inclusively from slot 0; otherwise search after cur_slot.
  assign search_start = (state == IDLE) ? '0 : cur_slot + SW'(1);

  led_cube_next_slot #(.NUM_SLOTS(NUM_SLOTS)) u_next_slot (
    .valid_vec (valid_vec),
    .start     (search_start),
    .found     (next_found),
    .index     (next_idx)
  );

  assign frame_start = (state == RUN) && (timer == '0) && !pause && !stop;
  assign playing     = (state != IDLE);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state and datapath update; stop overrides everything else.
  always_comb begin
    state_d       = state;
    anim_sel_d    = anim_sel;
    cur_slot_d    = cur_slot;
    loops_q_d     = loops_q;
    loop_cnt_d    = loop_cnt;
    frame_index_d = frame_index;
    timer_d       = timer;
    done_seen_d   = done_seen;
    overrun_d     = overrun;
    load_slot_d   = load_slot;
    empty_err_d   = 1'b0;
    advance       = 1'b0;

    if (stop) begin
      state_d       = IDLE;
      anim_sel_d    = '0;
      frame_index_d = '0;
      loop_cnt_d    = '0;
      timer_d       = '0;
      done_seen_d   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (play) begin
            overrun_d = 1'b0;
            if (next_found) begin
              state_d     = LOAD;
              load_slot_d = next_idx;
            end else begin
              empty_err_d = 1'b1;
            end
          end
        end
        LOAD: begin
          anim_sel_d    = ANIM_W'(slots[load_slot].anim_id);
          loops_q_d     = LOOP_W'(slots[load_slot].loops);
          cur_slot_d    = load_slot;
          frame_index_d = '0;
          loop_cnt_d    = '0;
          timer_d       = '0;
          done_seen_d   = 1'b0;
          state_d       = RUN;
        end
        RUN: begin
          if (pause) begin
            // frame_start is suppressed here, so any done pulse still counts.
            done_seen_d = done_seen | frame_done;
            state_d     = PAUSED;
          end else begin
            done_seen_d = frame_start ? 1'b0 : (done_seen | frame_done);
            if (timer == TIMER_LAST) begin
              if (done_seen || frame_done) begin
                advance = 1'b1;
              end else begin
                state_d   = WAIT_DONE;
                overrun_d = 1'b1;
              end
            end else begin
              timer_d = timer + TW'(1);
            end
          end
        end
        WAIT_DONE: begin
          if (frame_done) advance = 1'b1;
        end
        PAUSED: begin
          if (!pause) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase

      if (advance) begin
        state_d     = RUN;
        timer_d     = '0;
        done_seen_d = 1'b0;
        if (frame_index == FRAME_LAST) begin
          frame_index_d = '0;
          if (loop_cnt == loops_q) begin
            if (next_found) begin
              state_d     = LOAD;
              load_slot_d = next_idx;
            end else begin
              state_d    = IDLE;
              anim_sel_d = '0;
            end
          end else begin
            loop_cnt_d = loop_cnt + LOOP_W'(1);
          end
        end else begin
          frame_index_d = frame_index + 8'd1;
        end
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      anim_sel    <= '0;
      cur_slot    <= '0;
      loops_q     <= '0;
      loop_cnt    <= '0;
      frame_index <= '0;
      timer       <= '0;
      done_seen   <= 1'b0;
      overrun     <= 1'b0;
      load_slot   <= '0;
      empty_err   <= 1'b0;
    end else begin
      anim_sel    <= anim_sel_d;
      cur_slot    <= cur_slot_d;
      loops_q     <= loops_q_d;
      loop_cnt    <= loop_cnt_d;
      frame_index <= frame_index_d;
      timer       <= timer_d;
      done_seen   <= done_seen_d;
      overrun     <= overrun_d;
      load_slot   <= load_slot_d;
      empty_err   <= empty_err_d;
    end
  end

endmodule

// File: tb/tb_led_cube_playlist_scheduler.sv
// Directed self-checking bench for led_cube_playlist_scheduler with
// FRAME_TICKS=4 and FRAMES_PER_ANIM=3.
module tb_led_cube_playlist_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic       cfg_valid = 1'b0;
  logic [2:0] cfg_anim = '0;
  logic [2:0] cfg_loops = '0;
  logic       play = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       frame_done = 1'b0;
  logic       frame_start;
  logic [7:0] frame_index;
  logic [2:0] anim_sel;
  logic       playing;
  logic [2:0] cur_slot;
  logic       overrun;
  logic       empty_err;

  int n_vec = 0;
  int n_err = 0;
  int fs_cnt = 0;
  logic auto_done = 1'b1;
  logic last_fs = 1'b0;

  led_cube_playlist_scheduler #(
    .NUM_SLOTS(8), .FRAME_TICKS(4), .FRAMES_PER_ANIM(3), .ANIM_W(3), .LOOP_W(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_valid(cfg_valid), .cfg_anim(cfg_anim), .cfg_loops(cfg_loops),
    .play(play), .stop(stop), .pause(pause), .frame_done(frame_done),
    .frame_start(frame_start), .frame_index(frame_index), .anim_sel(anim_sel),
    .playing(playing), .cur_slot(cur_slot), .overrun(overrun), .empty_err(empty_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample frame_start mid-cycle, then answer it with a
  // frame_done pulse in the following cycle when auto_done is set.
  task automatic step();
    @(negedge clk);
    last_fs = frame_start;
    if (frame_start) fs_cnt++;
    @(posedge clk);
    #1;
    frame_done = auto_done & last_fs;
  endtask

  task automatic wr(input logic [2:0] a, input logic v, input logic [2:0] an, input logic [2:0] lp);
    cfg_we = 1'b1; cfg_addr = a; cfg_valid = v; cfg_anim = an; cfg_loops = lp;
    step();
    cfg_we = 1'b0;
  endtask

  initial begin
    // Reset
    step(); step();
    chk("rst_playing", playing, 0);
    chk("rst_fstart", frame_start, 0);
    chk("rst_findex", frame_index, 0);
    chk("rst_anim", anim_sel, 0);
    chk("rst_slot", cur_slot, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_empty", empty_err, 0);
    rst_n = 1'b1;
    step();

    // Test 1: single slot, two passes, wraps to itself
    wr(3'd0, 1'b1, 3'd2, 3'd1);
    play = 1'b1; step(); play = 1'b0;
    chk("t1_load_playing", playing, 1);
    chk("t1_load_fstart", frame_start, 0);
    step();
    chk("t1_anim", anim_sel, 2);
    fs_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      chk("t1_fstart", frame_start, 1);
      chk("t1_findex", frame_index, k % 3);
      repeat (4) step();
    end
    chk("t1_fs_count", fs_cnt, 6);
    chk("t1_reload_fstart", frame_start, 0);
    chk("t1_reload_playing", playing, 1);
    step();
    chk("t1_wrap_fstart", frame_start, 1);
    chk("t1_wrap_slot", cur_slot, 0);
    chk("t1_wrap_findex", frame_index, 0);
    chk("t1_overrun", overrun, 0);
    stop = 1'b1; step(); stop = 1'b0;
    chk("t1_stop_playing", playing, 0);
    chk("t1_stop_anim", anim_sel, 0);

    // Test 2: slots 1 and 5 alternate, others skipped
    wr(3'd0, 1'b0, 3'd0, 3'd0);
    wr(3'd1, 1'b1, 3'd3, 3'd0);
    wr(3'd5, 1'b1, 3'd6, 3'd0);
    play = 1'b1; step(); play = 1'b0;
    step();
    for (int r = 0; r < 3; r++) begin
      chk("t2_slot", cur_slot, (r == 1) ? 5 : 1);
      chk("t2_anim", anim_sel, (r == 1) ? 6 : 3);
      chk("t2_fstart", frame_start, 1);
      fs_cnt = 0;
      repeat (12) step();
      chk("t2_fs_count", fs_cnt, 3);
      chk("t2_load_fstart", frame_start, 0);
      step();
    end
    chk("t2_final_slot", cur_slot, 5);
    stop = 1'b1; step(); stop = 1'b0;

    // Test 3: frame_done withheld on frame 1 -> overrun
    play = 1'b1; step(); play = 1'b0;
    step();
    repeat (4) step();
    chk("t3_f1_findex", frame_index, 1);
    chk("t3_f1_fstart", frame_start, 1);
    auto_done = 1'b0;
    repeat (4) step();
    chk("t3_overrun", overrun, 1);
    chk("t3_wait_fstart", frame_start, 0);
    repeat (5) step();
    chk("t3_hold_findex", frame_index, 1);
    chk("t3_hold_playing", playing, 1);
    frame_done = 1'b1;
    step();
    auto_done = 1'b1;
    chk("t3_adv_findex", frame_index, 2);
    chk("t3_adv_fstart", frame_start, 1);
    stop = 1'b1; step(); stop = 1'b0;
    chk("t3_sticky_overrun", overrun, 1);
    chk("t3_stop_playing", playing, 0);
    play = 1'b1; step(); play = 1'b0;
    chk("t3_play_clears_overrun", overrun, 0);

    // Test 4: pause mid-frame
    step();
    chk("t4_fstart0", frame_start, 1);
    step(); step();
    pause = 1'b1;
    fs_cnt = 0;
    repeat (10) step();
    chk("t4_pause_fs_count", fs_cnt, 0);
    chk("t4_pause_findex", frame_index, 0);
    chk("t4_pause_playing", playing, 1);
    pause = 1'b0;
    step(); step();
    chk("t4_resume_fstart", frame_start, 0);
    chk("t4_resume_findex", frame_index, 0);
    step();
    chk("t4_next_fstart", frame_start, 1);
    chk("t4_next_findex", frame_index, 1);
    stop = 1'b1; step(); stop = 1'b0;

    // Test 5: playlist emptied during playback, then empty play
    wr(3'd1, 1'b0, 3'd0, 3'd0);
    wr(3'd5, 1'b0, 3'd0, 3'd0);
    wr(3'd0, 1'b1, 3'd4, 3'd0);
    play = 1'b1; step(); play = 1'b0;
    step();
    wr(3'd0, 1'b0, 3'd0, 3'd0);
    repeat (10) step();
    chk("t5_last_playing", playing, 1);
    chk("t5_last_findex", frame_index, 2);
    chk("t5_latched_anim", anim_sel, 4);
    step();
    chk("t5_end_playing", playing, 0);
    chk("t5_end_anim", anim_sel, 0);
    play = 1'b1; step(); play = 1'b0;
    chk("t5_empty_err", empty_err, 1);
    chk("t5_empty_playing", playing, 0);
    step();
    chk("t5_empty_pulse_end", empty_err, 0);

    // Test 6: stop+play collision, then reset mid-run
    wr(3'd2, 1'b1, 3'd5, 3'd2);
    play = 1'b1; step(); play = 1'b0;
    step();
    chk("t6_slot", cur_slot, 2);
    chk("t6_anim", anim_sel, 5);
    step(); step();
    stop = 1'b1; play = 1'b1; step(); stop = 1'b0; play = 1'b0;
    chk("t6_collide_playing", playing, 0);
    chk("t6_collide_findex", frame_index, 0);
    chk("t6_collide_anim", anim_sel, 0);
    step();
    chk("t6_collide_idle", playing, 0);
    play = 1'b1; step(); play = 1'b0;
    step(); step(); step();
    chk("t6_run_playing", playing, 1);
    rst_n = 1'b0; step();
    chk("t6_rst_playing", playing, 0);
    chk("t6_rst_fstart", frame_start, 0);
    chk("t6_rst_findex", frame_index, 0);
    chk("t6_rst_anim", anim_sel, 0);
    chk("t6_rst_slot", cur_slot, 0);
    chk("t6_rst_overrun", overrun, 0);
    rst_n = 1'b1;
    play = 1'b1; step(); play = 1'b0;
    chk("t6_rst_slots_invalid", empty_err, 1);
    chk("t6_rst_stays_idle", playing, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
